fp_mult_pipe: RTL and testbench
===============================

# fp_mult_pipe

Pipelined, multi-lane signed fixed-point multiplier with a valid/ready handshake, selectable rounding and selectable saturation. It generalises the combinational fixed-point multiply: it sits between the colour-transform datapath stages and can process one pixel's channels per transfer. It tolerates downstream backpressure without losing data.

## Interface
- `FP_WIDTH`, default `` `fp_width `` (16): total operand/result width, two's complement.
- `FP_FRAC`, default `` `fp_frac `` (8): fractional bits; 0 ≤ FP_FRAC < FP_WIDTH.
- `LANES`, default 3: independent multiplies per transfer.
- `STAGES`, default 2: register stages, ≥ 1.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  input beat present.
- `in_ready`  out  1  block accepts the beat this cycle.
- `a`  in  LANES*FP_WIDTH  multiplicands; lane i occupies bits [i*FP_WIDTH +: FP_WIDTH].
- `b`  in  LANES*FP_WIDTH  multipliers, same packing.
- `round_en`  in  1  1 = round half toward +inf; 0 = truncate. Sampled per beat.
- `sat_en`  in  1  1 = clamp on overflow; 0 = wrap. Sampled per beat.
- `out_valid`  out  1  result beat present.
- `out_ready`  in  1  downstream accepts the result.
- `out`  out  LANES*FP_WIDTH  products, same packing.
- `ovf`  out  LANES  per-lane overflow flag, aligned with `out`.

## Operation
- Per lane: full product p = a*b, signed, 2*FP_WIDTH bits, sign-extended to 2*FP_WIDTH+1 bits.
- Rounding: if round_en and FP_FRAC > 0, compute p' = p + 2^(FP_FRAC-1); otherwise p' = p.
- Result field: r = p'[FP_WIDTH-1+FP_FRAC : FP_FRAC].
- Overflow: ovf = 1 unless bits p'[2*FP_WIDTH : FP_WIDTH-1+FP_FRAC] are all equal.
- On overflow:
  - if sat_en, out = 0x7FFF when p' ≥ 0, or 0x8000 when p' < 0 (values for FP_WIDTH=16; in general max/min signed).
  - otherwise out = r (wrap).
- ovf is reported independently of sat_en.
- The round_en and sat_en values sampled at acceptance travel with their beat. Changing the mode pins never affects beats already in flight.
- Lanes share the handshake. All lanes of a beat emerge together.

## Timing
- Transfer occurs on an edge where valid && ready is high, on either side.
- Stall-all pipeline:
  - advance = out_ready || !out_valid.
  - in_ready = advance, combinational from out_ready and internal state.
- Stage usage:
  - stage 1 registers raw products and mode bits;
  - the last stage registers the rounded/saturated result and ovf;
  - extra stages (STAGES > 2) are pure delay;
  - STAGES = 1 does everything in one stage.
- Latency: exactly STAGES cycles from accept to out_valid when out_ready is held high. Throughput is 1 beat/cycle.
- Bubbles: per-stage valid bits. Bubbles are not squeezed; a bubble advances like data.
- Hold: while out_valid && !out_ready, `out`, `ovf` and out_valid stay stable, and in_ready = 0.
- Ordering: beats exit in acceptance order. No drops, no duplicates.
- Reset, asserted at any time including mid-stream:
  - all valid bits, out_valid, out and ovf go to 0 immediately;
  - in-flight beats are discarded;
  - in_ready = 1 after reset, since out_valid = 0.
- Simultaneous accept and drain at a full pipeline is legal and sustains full rate.

## Structure
- `datapath.vh` provides the defaults: `` `fp_width ``, `` `fp_frac ``, plus new `` `fp_lanes `` and `` `fp_mult_stages ``. No other shared types.
- Sub-module `fp_mult_lane`: one lane's multiply/round/overflow/saturate datapath with its stage registers, enabled by the shared advance signal.
- `fp_mult_pipe` holds:
  - the valid shift chain;
  - the handshake logic;
  - the LANES-wide generate loop of `fp_mult_lane`.

## Test plan
All scenarios use FP_WIDTH=16, FP_FRAC=8, LANES=3, STAGES=2.
- Basic:
  - stimulus: lane0 a=0x0180 (1.5), b=0x0200 (2.0); lane1 a=0xFF00 (−1), b=0x0300; lane2 a=0, b=0x7FFF; both modes 0.
  - response: out = {0x0000, 0xFD00, 0x0300}, ovf=0, out_valid exactly 2 cycles after accept.
- Rounding:
  - stimulus: a=0x0001, b=0x0080.
  - response: truncate → 0x0000; round_en=1 → 0x0001. With a=0xFFFF, b=0x0080, round_en=1 → 0x0000.
- Overflow:
  - stimulus: a=0x7F00, b=0x0200.
  - response: sat_en=0 → 0xFE00, ovf=1; sat_en=1 → 0x7FFF, ovf=1. Separately, a=0xFF00, b=0x8000, sat_en=1 → 0x7FFF, ovf=1.
- Backpressure:
  - stimulus: 20 random beats at full rate, with out_ready low for 5 cycles mid-stream.
  - response: in_ready low while stalled, outputs stable, all 20 results in order and matching the reference model, 1 beat/cycle after release.
- Mode per beat:
  - stimulus: toggle sat_en every beat at full rate on overflowing operands.
  - response: each result reflects its own sampled mode.
- Reset mid-stream:
  - stimulus: assert rst asynchronously with 2 beats in flight.
  - response: out_valid=0, out=0, ovf=0 immediately; no stale beat after release; next accepted beat is correct after 2 cycles.

Source files
------------

// File: rtl/fp_mult_pipe_pkg.sv
// Shared defaults and small types for the pipelined fixed-point multiplier.
package fp_mult_pipe_pkg;

   // Default datapath geometry: Q8.8 operands, one pixel (3 channels) per beat.
   localparam int FP_WIDTH_DEF       = 16;
   localparam int FP_FRAC_DEF        = 8;
   localparam int FP_LANES_DEF       = 3;
   localparam int FP_MULT_STAGES_DEF = 2;

   // Per-beat mode bits; they travel down the pipe alongside the product.
   typedef struct packed {
      logic round_en;
      logic sat_en;
   } fp_mode_t;

endpackage

// File: rtl/fp_mult_lane.sv
// One lane: signed multiply, optional round-half-up, overflow detect and
// optional saturation, with its stage registers gated by the shared advance.
module fp_mult_lane
   import fp_mult_pipe_pkg::*;
#(
   parameter int W      = FP_WIDTH_DEF,
   parameter int F      = FP_FRAC_DEF,
   parameter int STAGES = FP_MULT_STAGES_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         adv_i,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  fp_mode_t     mode_i,
   output logic [W-1:0] res_o,
   output logic         ovf_o
);

   // One guard bit above the full product so the rounding add cannot wrap.
   localparam int PW  = 2*W + 1;
   localparam int TOP = W - 1 + F;
   localparam logic [PW-1:0] HALF = (F > 0) ? (PW'(1) << ((F > 0) ? F - 1 : 0)) : '0;
   localparam logic [W-1:0] MAX_VAL = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

   logic signed [PW-1:0] a_ext;
   logic signed [PW-1:0] b_ext;
   logic signed [PW-1:0] prod_raw;
   logic signed [PW-1:0] sel_p;
   fp_mode_t             sel_mode;

   assign a_ext    = {{(W+1){a_i[W-1]}}, a_i};
   assign b_ext    = {{(W+1){b_i[W-1]}}, b_i};
   assign prod_raw = a_ext * b_ext;

   if (STAGES == 1) begin : g_single
      // Single stage: round/saturate straight from the inputs.
      assign sel_p    = prod_raw;
      assign sel_mode = mode_i;
   end else begin : g_prod_pipe
      logic signed [PW-1:0] prod_q [STAGES-1];
      fp_mode_t             mode_q [STAGES-1];

      // Stage 1 captures raw products and modes; deeper entries are pure delay.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int i = 0; i < STAGES-1; i++) begin
               prod_q[i] <= '0;
               mode_q[i] <= '0;
            end
         end else if (adv_i) begin
            prod_q[0] <= prod_raw;
            mode_q[0] <= mode_i;
            for (int i = 1; i < STAGES-1; i++) begin
               prod_q[i] <= prod_q[i-1];
               mode_q[i] <= mode_q[i-1];
            end
         end
      end

      assign sel_p    = prod_q[STAGES-2];
      assign sel_mode = mode_q[STAGES-2];
   end

   logic [PW-1:0]       rnd_p;
   logic [PW-1-TOP:0]   top_bits;
   logic [W-1:0]        res_d;
   logic                ovf_d;
   logic [W-1:0]        res_q;
   logic                ovf_q;
   logic                unused_rnd;

   // Round, extract the result field, detect overflow and clamp if asked.
   always_comb begin
      rnd_p = sel_p;
      if (sel_mode.round_en) begin
         rnd_p = sel_p + HALF;
      end
      top_bits = rnd_p[PW-1:TOP];
      ovf_d    = !((&top_bits) || !(|top_bits));
      res_d    = rnd_p[TOP:F];
      if (ovf_d && sel_mode.sat_en) begin
         res_d = rnd_p[PW-1] ? MIN_VAL : MAX_VAL;
      end
   end

   // Fraction bits below the result field are intentionally dropped.
   assign unused_rnd = ^rnd_p;

   // Last stage: registered result and overflow flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_q <= '0;
         ovf_q <= 1'b0;
      end else if (adv_i) begin
         res_q <= res_d;
         ovf_q <= ovf_d;
      end
   end

   assign res_o = res_q;
   assign ovf_o = ovf_q;

endmodule

// File: rtl/fp_mult_pipe.sv
// Multi-lane pipelined fixed-point multiplier with a stall-all valid/ready pipe.
//
// Handshake: a beat moves on a rising edge where valid && ready are both high.
// The whole pipe advances when out_ready || !out_valid; in_ready equals that
// advance term, so a stalled output back-pressures the input in the same cycle
// and bubbles move through like data.
module fp_mult_pipe
   import fp_mult_pipe_pkg::*;
#(
   parameter int FP_WIDTH = FP_WIDTH_DEF,
   parameter int FP_FRAC  = FP_FRAC_DEF,
   parameter int LANES    = FP_LANES_DEF,
   parameter int STAGES   = FP_MULT_STAGES_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [LANES*FP_WIDTH-1:0] a,
   input  logic [LANES*FP_WIDTH-1:0] b,
   input  logic                      round_en,
   input  logic                      sat_en,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [LANES*FP_WIDTH-1:0] out,
   output logic [LANES-1:0]          ovf
);

   logic              advance;
   logic [STAGES-1:0] vld_q;
   logic [STAGES-1:0] vld_d;
   fp_mode_t          mode_in;

   assign out_valid = vld_q[STAGES-1];
   assign advance   = out_ready || !out_valid;
   assign in_ready  = advance;

   assign mode_in.round_en = round_en;
   assign mode_in.sat_en   = sat_en;

   // Valid shift chain: shifts only when the pipe advances.
   always_comb begin
      vld_d = vld_q;
      if (advance) begin
         vld_d[0] = in_valid;
         for (int i = 1; i < STAGES; i++) begin
            vld_d[i] = vld_q[i-1];
         end
      end
   end

   // Valid register; reset discards every in-flight beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q <= '0;
      end else begin
         vld_q <= vld_d;
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      fp_mult_lane #(
         .W      (FP_WIDTH),
         .F      (FP_FRAC),
         .STAGES (STAGES)
      ) u_lane (
         .clk    (clk),
         .rst    (rst),
         .adv_i  (advance),
         .a_i    (a[g*FP_WIDTH +: FP_WIDTH]),
         .b_i    (b[g*FP_WIDTH +: FP_WIDTH]),
         .mode_i (mode_in),
         .res_o  (out[g*FP_WIDTH +: FP_WIDTH]),
         .ovf_o  (ovf[g])
      );
   end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Self-checking bench for fp_mult_pipe (16-bit Q8.8, 3 lanes, 2 stages).
module tb_fp_mult_pipe;

   localparam int W  = 16;
   localparam int F  = 8;
   localparam int L  = 3;
   localparam int S  = 2;
   localparam int DW = L*W;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] a;
   logic [DW-1:0] b;
   logic          round_en;
   logic          sat_en;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out;
   logic [L-1:0]  ovf;

   logic [DW+L-1:0] exp_q[$];
   int              n_chk = 0;
   int              n_fail = 0;
   int              cyc = 0;
   int              acc_cnt = 0;
   int              stall_cnt = 0;
   int              last_pop = 0;
   logic            hold_prev = 1'b0;
   logic [DW+L-1:0] hold_val;

   fp_mult_pipe #(
      .FP_WIDTH (W),
      .FP_FRAC  (F),
      .LANES    (L),
      .STAGES   (S)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .round_en  (round_en),
      .sat_en    (sat_en),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .ovf       (ovf)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc = cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- checker ----------------
   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_chk++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, expv, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Arithmetic view: result = floor((a*b [+ half]) / 2^F); it overflows when
   // that quotient lies outside the signed W-bit range.
   function automatic logic [DW+L-1:0] model(input logic [DW-1:0] ma, input logic [DW-1:0] mb,
                                              input logic rnd, input logic sat);
      logic [DW-1:0] o;
      logic [L-1:0]  v;
      longint        p;
      longint        q;
      o = '0;
      v = '0;
      for (int i = 0; i < L; i++) begin
         p = longint'($signed(ma[i*W +: W])) * longint'($signed(mb[i*W +: W]));
         if (rnd) p = p + (longint'(1) << (F-1));
         q = p >>> F;
         if (q > 32767 || q < -32768) begin
            v[i] = 1'b1;
            if (sat) o[i*W +: W] = (q > 0) ? 16'h7FFF : 16'h8000;
            else     o[i*W +: W] = q[W-1:0];
         end else begin
            o[i*W +: W] = q[W-1:0];
         end
      end
      return {v, o};
   endfunction

   function automatic logic [DW-1:0] rnd_word();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[DW-1:0];
   endfunction

   // ---------------- scoreboard / monitor ----------------
   always @(negedge clk) begin
      logic [DW+L-1:0] e;
      if (!rst) begin
         if (in_valid && in_ready) begin
            exp_q.push_back(model(a, b, round_en, sat_en));
            acc_cnt++;
         end
         if (out_valid && !out_ready) begin
            stall_cnt++;
            check_eq("stall_in_ready", 64'(in_ready), 64'(0));
            if (hold_prev) check_eq("stall_hold", 64'({ovf, out}), 64'(hold_val));
            hold_prev = 1'b1;
            hold_val  = {ovf, out};
         end else begin
            hold_prev = 1'b0;
         end
         if (out_valid && out_ready) begin
            check_eq("no_spurious", 64'(exp_q.size() > 0), 64'(1));
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check_eq("sb_out", 64'(out), 64'(e[DW-1:0]));
               check_eq("sb_ovf", 64'(ovf), 64'(e[DW +: L]));
               last_pop = cyc;
            end
         end
      end else begin
         hold_prev = 1'b0;
      end
   end

   // ---------------- driver tasks ----------------
   // All drivers start and end at posedge+1.
   task automatic send_beat(input logic [DW-1:0] sa, input logic [DW-1:0] sb,
                            input logic rnd, input logic sat);
      logic acc;
      a        = sa;
      b        = sb;
      round_en = rnd;
      sat_en   = sat;
      in_valid = 1'b1;
      acc      = 1'b0;
      for (int k = 0; k < 200 && !acc; k++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
      end
      if (!acc) check_eq("send_timeout", 64'(acc), 64'(1));
      in_valid = 1'b0;
   endtask

   task automatic run_one(input string tag, input logic [DW-1:0] sa, input logic [DW-1:0] sb,
                          input logic rnd, input logic sat,
                          input logic [DW-1:0] exp_out, input logic [L-1:0] exp_ovf);
      int lat;
      a        = sa;
      b        = sb;
      round_en = rnd;
      sat_en   = sat;
      in_valid = 1'b1;
      @(negedge clk);
      check_eq({tag, "_rdy"}, 64'(in_ready), 64'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (out_valid) begin
            lat = k;
            break;
         end
      end
      check_eq({tag, "_lat"}, 64'(lat), 64'(S));
      check_eq({tag, "_out"}, 64'(out), 64'(exp_out));
      check_eq({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int k = 0; k < 200 && exp_q.size() > 0; k++) @(negedge clk);
      check_eq("drain_empty", 64'(exp_q.size()), 64'(0));
      @(posedge clk);
      #1;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int c_s;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      round_en  = 1'b0;
      sat_en    = 1'b0;
      #1;
      check_eq("rst_out_valid", 64'(out_valid), 64'(0));
      check_eq("rst_out", 64'(out), 64'(0));
      check_eq("rst_ovf", 64'(ovf), 64'(0));
      check_eq("rst_in_ready", 64'(in_ready), 64'(1));
      repeat (2) @(posedge clk);
      @(negedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      #1;

      // Basic
      run_one("basic", {16'h0000, 16'hFF00, 16'h0180}, {16'h7FFF, 16'h0300, 16'h0200},
              1'b0, 1'b0, {16'h0000, 16'hFD00, 16'h0300}, 3'b000);

      // Rounding
      run_one("rnd_trunc", {32'h0, 16'h0001}, {32'h0, 16'h0080}, 1'b0, 1'b0, {32'h0, 16'h0000}, 3'b000);
      run_one("rnd_up",    {32'h0, 16'h0001}, {32'h0, 16'h0080}, 1'b1, 1'b0, {32'h0, 16'h0001}, 3'b000);
      run_one("rnd_neg",   {32'h0, 16'hFFFF}, {32'h0, 16'h0080}, 1'b1, 1'b0, {32'h0, 16'h0000}, 3'b000);

      // Overflow
      run_one("ovf_wrap", {32'h0, 16'h7F00}, {32'h0, 16'h0200}, 1'b0, 1'b0, {32'h0, 16'hFE00}, 3'b001);
      run_one("ovf_sat",  {32'h0, 16'h7F00}, {32'h0, 16'h0200}, 1'b0, 1'b1, {32'h0, 16'h7FFF}, 3'b001);
      run_one("ovf_negneg", {32'h0, 16'hFF00}, {32'h0, 16'h8000}, 1'b0, 1'b1, {32'h0, 16'h7FFF}, 3'b001);
      drain();

      // Backpressure: 20 random beats, 5-cycle stall once the pipe is full
      acc_cnt   = 0;
      stall_cnt = 0;
      c_s       = cyc;
      fork
         begin
            for (int i = 0; i < 20; i++)
               send_beat(rnd_word(), rnd_word(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         end
         begin
            for (int k = 0; k < 200 && acc_cnt < 8; k++) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();
      check_eq("bp_accepted", 64'(acc_cnt), 64'(20));
      check_eq("bp_stall_cycles", 64'(stall_cnt), 64'(5));
      check_eq("bp_elapsed", 64'(last_pop - c_s), 64'(20 + 5 + S - 1));

      // Mode per beat: sat_en toggles on every overflowing beat
      for (int i = 0; i < 8; i++)
         send_beat({3{16'h7F00}}, {3{16'h0200}}, 1'b0, 1'(i % 2));
      drain();

      // Random traffic with random downstream readiness
      acc_cnt = 0;
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge clk);
                  #1;
               end
               send_beat(rnd_word(), rnd_word(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
         end
         begin
            for (int k = 0; k < 400 && acc_cnt < 40; k++) begin
               @(posedge clk);
               #1 out_ready = 1'($urandom_range(0, 2) != 0);
            end
            out_ready = 1'b1;
         end
      join
      out_ready = 1'b1;
      drain();
      check_eq("rand_accepted", 64'(acc_cnt), 64'(40));

      // Reset mid-stream with two beats in flight
      send_beat({3{16'h0123}}, {3{16'h0456}}, 1'b0, 1'b0);
      send_beat({3{16'h7F00}}, {3{16'h0200}}, 1'b0, 1'b1);
      #2 rst = 1'b1;
      exp_q.delete();
      #1;
      check_eq("mid_rst_out_valid", 64'(out_valid), 64'(0));
      check_eq("mid_rst_out", 64'(out), 64'(0));
      check_eq("mid_rst_ovf", 64'(ovf), 64'(0));
      @(negedge clk);
      check_eq("mid_rst_in_ready", 64'(in_ready), 64'(1));
      #2 rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check_eq("no_stale_beat", 64'(out_valid), 64'(0));
      end
      @(posedge clk);
      #1;
      run_one("post_rst", {16'h0000, 16'hFF00, 16'h0180}, {16'h7FFF, 16'h0300, 16'h0200},
              1'b0, 1'b0, {16'h0000, 16'hFD00, 16'h0300}, 3'b000);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
